// File: rtl/ones_pattern_gen_if.sv
// Pattern stream from ones_pattern_gen to its consumer.
// Valid/ready handshake carrying the pattern, its sequence index and a last flag.
interface ones_pattern_gen_if #(
  parameter int W = 16
) ();
  logic          vec_valid;
  logic          vec_ready;
  logic [W-1:0]  vec;
  logic          vec_last;
  logic [15:0]   vec_idx;

  modport master (
    output vec_valid,
    output vec,
    output vec_last,
    output vec_idx,
    input  vec_ready
  );

  modport slave (
    input  vec_valid,
    input  vec,
    input  vec_last,
    input  vec_idx,
    output vec_ready
  );
endinterface

// File: rtl/ones_pattern_gen.sv
// Enumerates every W-bit vector with exactly k bits set, in increasing numeric
// order, one vector per valid/ready transfer (Gosper's next-combination step).
module ones_pattern_gen #(
  parameter int W  = 16,
  parameter int KW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KW-1:0]     k,
  output logic              busy,
  output logic              done,
  output logic              err,
  ones_pattern_gen_if.master vec_if
);

  localparam int            CW  = $clog2(W);
  localparam logic [KW-1:0] W_K = KW'(W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [KW-1:0]   k_r;
  logic [W-1:0]    vec_r;
  logic [15:0]     vec_idx_r;
  logic            vec_valid_r;
  logic            vec_last_r;
  logic            busy_r;
  logic            done_r;
  logic            err_r;

  logic [W-1:0]    lowbit_s;
  logic [W-1:0]    ripple_s;
  logic [CW-1:0]   ctz_s;
  logic [W-1:0]    next_vec_s;
  logic [W-1:0]    first_pat_s;
  logic            first_is_last_s;
  logic [W-1:0]    last_pat_s;
  logic            xfer_s;

  // Lowest kk bits set: the first pattern of the sequence.
  function automatic logic [W-1:0] low_ones(input logic [KW-1:0] kk);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = (i < int'(kk));
    end
    return m;
  endfunction

  // Highest kk bits set: the final pattern of the sequence.
  function automatic logic [W-1:0] high_ones(input logic [KW-1:0] kk);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) begin
      m[i] = (i >= (W - int'(kk)));
    end
    return m;
  endfunction

  // Trailing-zero count of a one-hot (or zero) word; lowest set bit wins.
  function automatic logic [CW-1:0] ctz_pe(input logic [W-1:0] x);
    logic [CW-1:0] pos;
    pos = {CW{1'b0}};
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) begin
        pos = CW'(i);
      end
    end
    return pos;
  endfunction

  // Gosper step; only consumed when the current vector is not the last one,
  // so the ripple add never overflows W bits when its result is used.
  always_comb begin
    lowbit_s        = vec_r & (~vec_r + {{(W-1){1'b0}}, 1'b1});
    ripple_s        = vec_r + lowbit_s;
    ctz_s           = ctz_pe(lowbit_s);
    next_vec_s      = (((ripple_s ^ vec_r) >> 2'd2) >> ctz_s) | ripple_s;
    first_pat_s     = low_ones(k);
    first_is_last_s = (first_pat_s == high_ones(k));
    last_pat_s      = high_ones(k_r);
    xfer_s          = vec_valid_r & vec_if.vec_ready;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      k_r         <= {KW{1'b0}};
      vec_r       <= {W{1'b0}};
      vec_idx_r   <= 16'd0;
      vec_valid_r <= 1'b0;
      vec_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (k > W_K) begin
              err_r <= 1'b1;
            end else begin
              state_r     <= ST_EMIT;
              k_r         <= k;
              vec_r       <= first_pat_s;
              vec_idx_r   <= 16'd0;
              vec_valid_r <= 1'b1;
              vec_last_r  <= first_is_last_s;
              busy_r      <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (xfer_s) begin
            if (vec_last_r) begin
              state_r     <= ST_DONE;
              vec_valid_r <= 1'b0;
              vec_last_r  <= 1'b0;
              done_r      <= 1'b1;
            end else begin
              vec_r      <= next_vec_s;
              vec_idx_r  <= vec_idx_r + 16'd1;
              vec_last_r <= (next_vec_s == last_pat_s);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          vec_valid_r <= 1'b0;
          vec_last_r  <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign err              = err_r;
  assign vec_if.vec_valid = vec_valid_r;
  assign vec_if.vec       = vec_r;
  assign vec_if.vec_last  = vec_last_r;
  assign vec_if.vec_idx   = vec_idx_r;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen; expected patterns come from a brute-force
// "next number with k ones" search, independent of the Gosper step.
module tb_ones_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] k;
  logic       busy;
  logic       done;
  logic       err;

  int checks;
  int failures;

  ones_pattern_gen_if #(.W(16)) vif ();

  ones_pattern_gen #(.W(16), .KW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .k      (k),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .vec_if (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] first_pat(input int kk);
    logic [16:0] t;
    t = (17'd1 << kk) - 17'd1;
    return t[15:0];
  endfunction

  function automatic logic [15:0] next_model(input logic [15:0] x, input int kk);
    int v;
    v = int'(x) + 1;
    while (v < 65536 && $countones(v[15:0]) != kk) v++;
    return v[15:0];
  endfunction

  // Runs one enumeration; abort_at >= 0 resets the DUT when that index is shown.
  task automatic run_enum(input int kk, input int ready_pct, input int n_exp,
                          input int abort_at, input bit mid_start);
    logic [15:0] exp_v;
    int cnt;
    int cyc;
    bit fin;
    bit rdy;
    exp_v = first_pat(kk);
    cnt   = 0;
    cyc   = 0;
    fin   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    k     = 5'(kk);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 40000) begin
      check("valid",  {31'd0, vif.vec_valid}, 32'd1);
      check("vec",    {16'd0, vif.vec}, {16'd0, exp_v});
      check("idx",    {16'd0, vif.vec_idx}, cnt);
      check("last",   {31'd0, vif.vec_last}, (cnt == n_exp - 1) ? 32'd1 : 32'd0);
      check("popcnt", $countones(vif.vec), kk);
      check("busy",   {31'd0, busy}, 32'd1);
      check("done_lo", {31'd0, done}, 32'd0);
      if (cnt == abort_at) begin
        rst = 1'b1;
        vif.vec_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vif.vec_ready = 1'b0;
        check("rst_valid", {31'd0, vif.vec_valid}, 32'd0);
        check("rst_vec",   {16'd0, vif.vec}, 32'd0);
        check("rst_idx",   {16'd0, vif.vec_idx}, 32'd0);
        check("rst_last",  {31'd0, vif.vec_last}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        check("rst_nodone", {31'd0, done}, 32'd0);
        check("rst_idle",   {31'd0, vif.vec_valid}, 32'd0);
        return;
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      vif.vec_ready = rdy;
      start = mid_start && (cnt == 6000);
      if (start) k = 5'd3;
      if (rdy) begin
        cnt++;
        if (cnt == n_exp) fin = 1'b1;
        else exp_v = next_model(exp_v, kk);
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    vif.vec_ready = 1'b0;
    check("count", cnt, n_exp);
    check("end_valid", {31'd0, vif.vec_valid}, 32'd0);
    check("done_hi",   {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_busy",  {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, vif.vec_valid}, 32'd0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    start         = 1'b0;
    k             = 5'd0;
    vif.vec_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("r_valid", {31'd0, vif.vec_valid}, 32'd0);
    check("r_vec",   {16'd0, vif.vec}, 32'd0);
    check("r_idx",   {16'd0, vif.vec_idx}, 32'd0);
    check("r_last",  {31'd0, vif.vec_last}, 32'd0);
    check("r_busy",  {31'd0, busy}, 32'd0);
    check("r_done",  {31'd0, done}, 32'd0);
    check("r_err",   {31'd0, err}, 32'd0);
    rst = 1'b0;

    // k=2: 0x0003, 0x0005, 0x0006, ... 0xC000
    run_enum(2, 100, 120, -1, 1'b0);
    // single-vector boundaries
    run_enum(0, 100, 1, -1, 1'b0);
    run_enum(16, 100, 1, -1, 1'b0);

    // k=17 rejected
    @(negedge clk);
    start = 1'b1;
    k     = 5'd17;
    @(negedge clk);
    start = 1'b0;
    check("err_hi",    {31'd0, err}, 32'd1);
    check("err_valid", {31'd0, vif.vec_valid}, 32'd0);
    check("err_busy",  {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("err_pulse", {31'd0, err}, 32'd0);
    check("err_valid2", {31'd0, vif.vec_valid}, 32'd0);
    check("err_busy2", {31'd0, busy}, 32'd0);

    // backpressure
    run_enum(3, 50, 560, -1, 1'b0);
    // full k=8 with a stray start mid-run
    run_enum(8, 100, 12870, -1, 1'b1);
    // reset mid-enumeration, then a fresh k=1 run
    run_enum(4, 100, 1820, 40, 1'b0);
    run_enum(1, 100, 16, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
